// File: rtl/regfile_scoreboard.sv
// Eight-entry register file with write-through bypass and a per-register
// pending-writer scoreboard that raises a decode stall on RAW hazards.
module regfile_scoreboard #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    rd1_reg,
  input  logic [2:0]    rd2_reg,
  input  logic          rd1_used,
  input  logic          rd2_used,
  output logic [DW-1:0] rd1_data,
  output logic [DW-1:0] rd2_data,
  input  logic          wr_en,
  input  logic [2:0]    wr_reg,
  input  logic [DW-1:0] write_data,
  input  logic          issue_en,
  input  logic [2:0]    issue_reg,
  input  logic          flush,
  output logic          hazard,
  output logic          err
);

  logic [DW-1:0]   regs_q [NREG];
  logic [1:0]      cnt_q  [NREG];
  logic [1:0]      cnt_d  [NREG];
  logic [NREG-1:0] ovf;
  logic [NREG-1:0] unf;
  logic            err_q;
  logic            err_d;
  logic            busy1;
  logic            busy2;

  // Returns {overflow, underflow, next_count}. An issue and a write to the
  // same register cancel, so the count (and err) is untouched at any value.
  function automatic logic [3:0] cnt_step(
    input logic [1:0] cnt,
    input logic       inc,
    input logic       dec,
    input logic       flsh
  );
    logic [3:0] res;
    res = {2'b00, cnt};
    if (flsh) begin
      res = 4'b0000;
    end else if (inc && !dec) begin
      if (cnt == 2'd3) res = {2'b10, cnt};
      else             res = {2'b00, cnt + 2'd1};
    end else if (dec && !inc) begin
      if (cnt == 2'd0) res = {2'b01, cnt};
      else             res = {2'b00, cnt - 2'd1};
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic inc;
    logic dec;

    assign inc = issue_en && (issue_reg == 3'(gi));
    assign dec = wr_en && (wr_reg == 3'(gi));
    assign {ovf[gi], unf[gi], cnt_d[gi]} = cnt_step(cnt_q[gi], inc, dec, flush);

    // Data still lands during a flush; only the scoreboard is squashed.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        regs_q[gi] <= '0;
        cnt_q[gi]  <= 2'd0;
      end else begin
        if (dec) regs_q[gi] <= write_data;
        cnt_q[gi] <= cnt_d[gi];
      end
    end
  end

  assign err_d = err_q | (|ovf) | (|unf);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign rd1_data = (wr_en && (wr_reg == rd1_reg)) ? write_data : regs_q[rd1_reg];
  assign rd2_data = (wr_en && (wr_reg == rd2_reg)) ? write_data : regs_q[rd2_reg];

  // A read is released when the last pending producer writes back this cycle.
  assign busy1 = rd1_used && (cnt_q[rd1_reg] != 2'd0) &&
                 !(wr_en && (wr_reg == rd1_reg) && (cnt_q[rd1_reg] == 2'd1));
  assign busy2 = rd2_used && (cnt_q[rd2_reg] != 2'd0) &&
                 !(wr_en && (wr_reg == rd2_reg) && (cnt_q[rd2_reg] == 2'd1));

  assign hazard = (busy1 || busy2) && !flush;
  assign err    = err_q;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning the number of architectural registers, fixed at 8 for this ISA.
REQ-002 SHALL have parameter DW, default 16, meaning the data width.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-005 SHALL have ports rd1_reg and rd2_reg, input, 3 bits each, meaning the read addresses from decode.
REQ-006 SHALL have ports rd1_used and rd2_used, input, 1 bit each, meaning the read operand is actually consumed.
REQ-007 SHALL have ports rd1_data and rd2_data, output, 16 bits each, meaning the combinational read data.
REQ-008 SHALL have port wr_en, input, 1 bit, meaning the writeback stage commits write_data this cycle.
REQ-009 SHALL have port wr_reg, input, 3 bits, meaning the writeback destination.
REQ-010 SHALL have port write_data, input, 16 bits, meaning the writeback result.
REQ-011 SHALL have port issue_en, input, 1 bit, meaning decode issues an instruction that will write issue_reg.
REQ-012 SHALL have port issue_reg, input, 3 bits, meaning the destination of the issued instruction.
REQ-013 SHALL have port flush, input, 1 bit, meaning a pipeline flush that squashes in-flight writers.
REQ-014 SHALL have port hazard, output, 1 bit, meaning the decode stage must stall.
REQ-015 SHALL have port err, output, 1 bit, meaning a sticky scoreboard over/underflow.

Function
REQ-016 SHALL hold 8 x 16-bit registers R0..R7; R0 is an ordinary writable register.
REQ-017 SHALL write write_data into R[wr_reg] on the rising edge when wr_en=1.
REQ-018 SHALL drive rdN_data = write_data combinationally when wr_en=1 and wr_reg==rdN_reg (write-through bypass); otherwise rdN_data = R[rdN_reg].
REQ-019 SHALL keep a 2-bit pending counter cnt[r] per register, counting issued-but-not-written producers.
REQ-020 SHALL increment cnt[issue_reg] per edge when issue_en=1 and flush=0.
REQ-021 SHALL decrement cnt[wr_reg] per edge when wr_en=1 and flush=0.
REQ-022 SHALL leave cnt unchanged when issue and write target the same register in the same cycle and cnt is 1 or 2.
REQ-023 SHALL hold cnt at 3 and set err when an issue hits cnt=3 without a same-register write (overflow).
REQ-024 SHALL hold cnt at 0 and set err when a write hits cnt=0 without a same-register issue (underflow).
REQ-025 SHALL clear all cnt to 0 on flush=1, with priority over issue and write; the R[] data write of REQ-017 still occurs.
REQ-026 SHALL define busyN = rdN_used & (cnt[rdN_reg]!=0) & ~(wr_en & wr_reg==rdN_reg & cnt[rdN_reg]==1).
REQ-027 SHALL drive hazard = (busy1 | busy2) & ~flush, combinationally.
REQ-028 SHALL NOT gate issue_en with hazard internally; decode must not assert issue_en while hazard=1.
REQ-029 SHALL keep err set until reset once asserted; err does not block other updates.
REQ-030 SHALL add zero latency to reads and one-edge latency to writes and counter updates.

Reset
REQ-031 SHALL on rst=0, asynchronously and independent of clk, clear R0..R7 to 0x0000, all cnt to 0 and err to 0.
REQ-032 SHALL therefore reset rd1_data/rd2_data to 0x0000 (absent bypass), hazard to 0 and err to 0.
REQ-033 SHALL, when reset asserts mid-operation, discard all pending counts and data; the first edge after deassertion behaves as a fresh start.

Verification
REQ-034 SHALL cover bypass: wr_en=1, wr_reg=3, write_data=0xBEEF, rd1_reg=3 -> rd1_data=0xBEEF in the same cycle, and R3=0xBEEF after the edge.
REQ-035 SHALL cover RAW stall: issue R5, then rd2_reg=5, rd2_used=1 -> hazard=1; wr_en to R5 -> hazard=0 in that cycle and cnt[5]=0 after the edge.
REQ-036 SHALL cover double issue: issue R2 twice, then write R2 once -> hazard with rd1_reg=2 stays 1; second write -> hazard 0.
REQ-037 SHALL cover overflow and underflow: issue R1 four times -> err=1, cnt[1]=3; after reset, write R6 with cnt=0 -> err=1.
REQ-038 SHALL cover flush: issue R4 and R7, flush=1 -> all cnt=0 and hazard=0, while a concurrent wr_en to R4 of 0x1234 still lands.
REQ-039 SHALL cover async reset: rst low between edges -> R*=0, hazard=0 and err=0 immediately, with no clk edge required.
